// File: rtl/ecc_link_tx.sv
// ecc_link_tx: transmit end of the ECC-protected link.
// Encodes 32-bit words into 39-bit SEC-DED frames, buffers them in a
// small FIFO and serializes each frame LSB-first as five 8-bit beats
// framed by SOP/EOP. An optional single-bit injection hook corrupts a
// chosen frame bit so the receiver's decoder can be exercised.
module ecc_link_tx #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_in,
   input  logic [31:0]              data_in,
   output logic                     ready_in,
   input  logic                     inj_en,
   input  logic [5:0]               inj_pos,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_sop,
   output logic                     tx_eop,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]         frames_sent
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   logic [38:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [LVL_W-1:0] r_count;
   state_t           r_state;
   state_t           w_nextState;
   logic [39:0]      r_shift;
   logic [2:0]       r_beat;
   logic [CNT_W-1:0] r_sent;

   logic [38:0]      w_frame;
   logic             w_push;
   logic             w_pop;
   logic             w_notEmpty;
   logic             w_beatAcc;
   logic             w_frameDone;

   // Hamming(38,32) plus overall parity; data bits fill every
   // non-power-of-two position 3..38, check bit i covers positions with bit i set.
   function automatic logic [38:0] encode(input logic [31:0] d);
      logic [38:0] cw;
      logic [5:0]  h;
      int          k;
      cw = '0;
      h  = '0;
      k  = 0;
      for (int p = 1; p <= 38; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p] = d[k];
            k++;
         end
      end
      for (int i = 0; i < 6; i++) begin
         for (int p = 1; p <= 38; p++) begin
            if (((p >> i) & 1) != 0) begin
               h[i] = h[i] ^ cw[p];
            end
         end
      end
      return {^{d, h}, h, d};
   endfunction

   assign ready_in    = (r_count != LVL_W'(DEPTH));
   assign w_push      = valid_in && ready_in;
   assign w_notEmpty  = (r_count != '0);
   assign fifo_level  = r_count;
   assign frames_sent = r_sent;

   assign tx_valid = (r_state == SEND);
   assign tx_data  = (r_state == SEND) ? r_shift[7:0] : 8'h00;
   assign tx_sop   = (r_state == SEND) && (r_beat == 3'd0);
   assign tx_eop   = (r_state == SEND) && (r_beat == 3'd4);

   // Encode the incoming word and apply the optional single-bit corruption.
   always_comb begin
      w_frame = encode(data_in);
      if (inj_en && (inj_pos <= 6'd38)) begin
         w_frame[inj_pos] = ~w_frame[inj_pos];
      end
   end

   // Frame storage; contents need no reset because the count guards reads.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= w_frame;
      end
   end

   // FIFO pointers and occupancy; push and pop together leave the level unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LVL_W'(1);
            2'b01:   r_count <= r_count - LVL_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Serializer next-state: load from FIFO when idle, chain frames back-to-back.
   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
      w_beatAcc   = 1'b0;
      w_frameDone = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_notEmpty) begin
               w_pop       = 1'b1;
               w_nextState = SEND;
            end
         end
         SEND: begin
            if (tx_ready) begin
               w_beatAcc = 1'b1;
               if (r_beat == 3'd4) begin
                  w_frameDone = 1'b1;
                  if (w_notEmpty) begin
                     w_pop = 1'b1;
                  end else begin
                     w_nextState = IDLE;
                  end
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Serializer state, shift register, beat index and sent-frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_beat  <= '0;
         r_sent  <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_pop) begin
            r_shift <= {1'b0, r_mem[r_rdPtr]};
            r_beat  <= '0;
         end else if (w_frameDone) begin
            r_shift <= '0;
            r_beat  <= '0;
         end else if (w_beatAcc) begin
            r_shift <= {8'h00, r_shift[39:8]};
            r_beat  <= r_beat + 3'd1;
         end
         if (w_frameDone) begin
            r_sent <= r_sent + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ecc_link_tx.sv
// tb_ecc_link_tx: self-checking bench for ecc_link_tx.
// Known frames from a vector table, hand-written stall and reset
// sequences, and a randomized run scored against a reference encoder.
module tb_ecc_link_tx;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] data_in = '0;
   logic        ready_in;
   logic        inj_en = 1'b0;
   logic [5:0]  inj_pos = '0;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_data;
   logic        tx_sop;
   logic        tx_eop;
   logic [$clog2(DEPTH):0] fifo_level;
   logic [CNT_W-1:0]       frames_sent;

   int          checks = 0;
   int          failures = 0;
   int          totalPushed = 0;
   int          posTable [32];
   logic [39:0] modelQ [$];
   bit          monOn = 1'b0;
   bit          haveFrame = 1'b0;
   int          monBeat = 0;
   logic [39:0] curFrame = '0;
   bit          doneFlag = 1'b0;

   typedef struct {
      logic [31:0] data;
      bit          injEn;
      logic [5:0]  injPos;
      logic [39:0] frame;
   } vec_t;

   vec_t vecs [9];

   ecc_link_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .ready_in   (ready_in),
      .inj_en     (inj_en),
      .inj_pos    (inj_pos),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_data    (tx_data),
      .tx_sop     (tx_sop),
      .tx_eop     (tx_eop),
      .fifo_level (fifo_level),
      .frames_sent(frames_sent)
   );

   always #5 clk = ~clk;

   // Reference encoder: check bits are the XOR of the positions of set data bits.
   function automatic logic [39:0] refFrame(input logic [31:0] d, input bit inj, input logic [5:0] pos);
      logic [5:0]  h;
      logic        g;
      logic [39:0] f;
      h = '0;
      for (int j = 0; j < 32; j++) begin
         if (d[j]) h = h ^ 6'(posTable[j]);
      end
      g = 1'(($countones(d) + $countones(h)) % 2);
      f = {1'b0, g, h, d};
      if (inj && pos <= 6'd38) f[pos] = ~f[pos];
      return f;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Presents one word from posedge+1 until accepted; records its expected frame.
   task automatic applyStimulus(input logic [31:0] d, input bit inj, input logic [5:0] pos);
      bit accepted;
      int waits;
      accepted = 1'b0;
      waits = 0;
      valid_in = 1'b1;
      data_in = d;
      inj_en = inj;
      inj_pos = pos;
      while (!accepted && waits < 500) begin
         @(negedge clk);
         if (ready_in) accepted = 1'b1;
         @(posedge clk);
         #1;
         waits++;
      end
      valid_in = 1'b0;
      inj_en = 1'b0;
      if (accepted) begin
         modelQ.push_back(refFrame(d, inj, pos));
         totalPushed++;
      end else begin
         checks++;
         failures++;
         $display("[TB] FAIL push_timeout: actual=not accepted required=accepted");
      end
   endtask

   task automatic waitDrained(input string name);
      int n;
      n = 0;
      while ((modelQ.size() != 0 || haveFrame || tx_valid) && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 64'(modelQ.size()) + 64'(haveFrame), 0);
   endtask

   // Beat monitor: every presented beat must match the reference frame and framing.
   always @(negedge clk) begin
      if (monOn) begin
         if (tx_valid) begin
            if (!haveFrame) begin
               if (modelQ.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL mon_unexpected_frame: actual=beat presented required=no beat");
               end else begin
                  curFrame = modelQ.pop_front();
               end
               haveFrame = 1'b1;
               monBeat = 0;
            end
            checkOutput("mon_data", tx_data, curFrame[8*monBeat +: 8]);
            checkOutput("mon_sop", tx_sop, monBeat == 0);
            checkOutput("mon_eop", tx_eop, monBeat == 4);
            if (tx_ready) begin
               monBeat++;
               if (monBeat == 5) begin
                  haveFrame = 1'b0;
                  monBeat = 0;
               end
            end
         end else if (haveFrame) begin
            checkOutput("mon_valid_gap", tx_valid, 1'b1);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: actual=still running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int p;
      int waitCycles;
      int gaps;
      logic [39:0] got;
      logic [CNT_W-1:0] sentBefore;

      p = 2;
      for (int j = 0; j < 32; j++) begin
         p++;
         while ((p & (p - 1)) == 0) p++;
         posTable[j] = p;
      end

      vecs[0] = '{32'h0000_0001, 1'b0, 6'd0,  40'h43_0000_0001};
      vecs[1] = '{32'hFFFF_FFFF, 1'b0, 6'd0,  40'h18_FFFF_FFFF};
      vecs[2] = '{32'h0000_0000, 1'b1, 6'd0,  40'h00_0000_0001};
      vecs[3] = '{32'h0000_0000, 1'b1, 6'd45, 40'h00_0000_0000};
      vecs[4] = '{32'h0000_0000, 1'b1, 6'd38, 40'h40_0000_0000};
      vecs[5] = '{32'h0000_0000, 1'b1, 6'd39, 40'h00_0000_0000};
      vecs[6] = '{32'h0000_0001, 1'b1, 6'd32, 40'h42_0000_0001};
      vecs[7] = '{32'h8000_0000, 1'b0, 6'd0,  40'h26_8000_0000};
      vecs[8] = '{32'h0000_0002, 1'b0, 6'd0,  40'h45_0000_0002};

      $display("[TB] reset");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ready_in", ready_in, 1'b1);
      checkOutput("rst_tx_valid", tx_valid, 1'b0);
      checkOutput("rst_tx_data", tx_data, 8'h00);
      checkOutput("rst_sop_eop", {tx_sop, tx_eop}, 2'b00);
      checkOutput("rst_fifo_level", fifo_level, 0);
      checkOutput("rst_frames_sent", frames_sent, 0);
      rst_n = 1'b1;

      $display("[TB] vector table");
      tx_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         #1;
         applyStimulus(vecs[i].data, vecs[i].injEn, vecs[i].injPos);
         waitCycles = 0;
         do begin
            @(negedge clk);
            waitCycles++;
         end while (!(tx_valid && tx_sop) && waitCycles < 20);
         checkOutput($sformatf("tbl_latency_%0d", i), waitCycles, 2);
         got = '0;
         for (int b = 0; b < 5; b++) begin
            if (b > 0) @(negedge clk);
            got[8*b +: 8] = tx_data;
            checkOutput($sformatf("tbl_framing_%0d_%0d", i, b),
                        {tx_valid, tx_sop, tx_eop}, {1'b1, b == 0, b == 4});
         end
         checkOutput($sformatf("tbl_frame_%0d", i), got, vecs[i].frame);
         @(negedge clk);
         checkOutput($sformatf("tbl_frames_sent_%0d", i), frames_sent, 16'(totalPushed));
      end
      modelQ.delete();

      $display("[TB] backpressure");
      monOn = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus($urandom, 1'b0, 6'd0);
      @(negedge clk);
      checkOutput("stall_ready_in", ready_in, 1'b0);
      checkOutput("stall_fifo_level", fifo_level, 4);
      checkOutput("stall_tx_valid", tx_valid, 1'b1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      tx_ready = 1'b1;
      gaps = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (!tx_valid) gaps++;
         if (k == 4) checkOutput("stall_ready_before_pop", ready_in, 1'b0);
         if (k == 5) checkOutput("stall_ready_after_pop", ready_in, 1'b1);
      end
      checkOutput("stall_gaps", gaps, 0);
      @(negedge clk);
      checkOutput("stall_idle", tx_valid, 1'b0);
      checkOutput("stall_frames_sent", frames_sent, 16'(totalPushed));
      checkOutput("stall_fifo_empty", fifo_level, 0);

      $display("[TB] random traffic");
      sentBefore = frames_sent;
      @(posedge clk);
      #1;
      doneFlag = 1'b0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               applyStimulus($urandom, $urandom_range(0, 3) == 0, 6'($urandom_range(0, 63)));
            end
            doneFlag = 1'b1;
         end
         begin
            while (!doneFlag) begin
               @(posedge clk);
               #1;
               tx_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      tx_ready = 1'b1;
      waitDrained("rand_drained");
      checkOutput("rand_frames_sent", frames_sent, 16'(totalPushed));
      checkOutput("rand_delta", 16'(frames_sent - sentBefore), 100);

      $display("[TB] reset mid-frame");
      monOn = 1'b0;
      modelQ.delete();
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      applyStimulus(32'hA5A5_5A5A, 1'b0, 6'd0);
      applyStimulus(32'h1234_5678, 1'b0, 6'd0);
      applyStimulus(32'h0BAD_F00D, 1'b0, 6'd0);
      tx_ready = 1'b1;
      waitCycles = 0;
      do begin
         @(negedge clk);
         waitCycles++;
      end while (!(tx_valid && tx_sop) && waitCycles < 20);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_pre_beat2", tx_data, 8'hA5);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rstmid_tx_valid", tx_valid, 1'b0);
      checkOutput("rstmid_tx_data", tx_data, 8'h00);
      checkOutput("rstmid_sop_eop", {tx_sop, tx_eop}, 2'b00);
      checkOutput("rstmid_ready_in", ready_in, 1'b1);
      checkOutput("rstmid_fifo_level", fifo_level, 0);
      checkOutput("rstmid_frames_sent", frames_sent, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      modelQ.delete();
      haveFrame = 1'b0;
      monBeat = 0;
      totalPushed = 0;
      gaps = 0;
      repeat (4) begin
         @(negedge clk);
         if (tx_valid) gaps++;
      end
      checkOutput("rstmid_no_leftover", gaps, 0);
      monOn = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus($urandom, 1'b0, 6'd0);
      waitDrained("rstmid_drained");
      checkOutput("rstmid_frames_after", frames_sent, 1);
      checkOutput("rstmid_fifo_after", fifo_level, 0);
      monOn = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
